// File: rtl/command_queue.sv
// Elastic command buffer between the I2C slave and the TPU: buffers 48-bit
// commands and replays them one at a time, paced by the TPU busy handshake.
module command_queue #(
    parameter int DEPTH        = 8,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_execute,
    input  logic [47:0]                  in_command,
    output logic                         in_busy,
    output logic                         out_execute,
    output logic [47:0]                  out_command,
    input  logic                         out_busy,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [3:0]       GUARD_LOAD = 4'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        WAIT
    } state_t;

    state_t             state, state_next;
    logic [3:0]         guard_cnt, guard_next;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W-1:0]   rd_next, wr_next;
    logic [LVL_W-1:0]   level_next;
    logic               full;
    logic               push_ok;
    logic               push_drop;
    logic               issue;

    // NOTE: storage carries no reset; validity is tracked by the pointers and level alone.
    logic [47:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= in_command;
        end
    end

    // Fullness is judged on the level at the start of the cycle, so a
    // same-cycle pop never makes room for a push into a full queue.
    assign full      = (level == FULL_LEVEL);
    assign push_ok   = in_execute && !full && !flush;
    assign push_drop = in_execute && full && !flush;
    assign issue     = (state == IDLE) && (level != '0) && !out_busy;

    always_comb begin
        wr_next    = wr_ptr + PTR_W'(push_ok);
        rd_next    = rd_ptr + PTR_W'(issue);
        level_next = level + LVL_W'(push_ok) - LVL_W'(issue);
        if (flush) begin
            rd_next    = wr_ptr;
            level_next = '0;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    state_next = GUARD;
                    guard_next = GUARD_LOAD;
                end
            end
            GUARD: begin
                // busy is not trusted yet: the TPU needs a few cycles to raise it
                if (guard_cnt <= 4'd1) begin
                    guard_next = '0;
                    state_next = WAIT;
                end else begin
                    guard_next = guard_cnt - 4'd1;
                end
            end
            WAIT: begin
                if (!out_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            guard_cnt   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            in_busy     <= 1'b0;
            out_execute <= 1'b0;
            out_command <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            state       <= state_next;
            guard_cnt   <= guard_next;
            rd_ptr      <= rd_next;
            wr_ptr      <= wr_next;
            level       <= level_next;
            in_busy     <= (level_next == FULL_LEVEL);
            out_execute <= issue;
            if (issue) begin
                out_command <= mem[rd_ptr];
            end
            if (push_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_command_queue.sv
// Self-checking bench for command_queue: vector table for fill/overflow,
// scoreboard of expected issued commands checked whenever out_execute fires.
module tb_command_queue;

    localparam int DEPTH = 4;
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_execute;
    logic [47:0] in_command;
    logic        in_busy;
    logic        out_execute;
    logic [47:0] out_command;
    logic        out_busy;
    logic        flush;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    logic        busy_man;
    logic        tpu_en;
    logic        tpu_busy;
    int          tpu_cnt = 0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [47:0] sb[$];

    int          cyc       = 0;
    int          last_exec = -1000;
    logic        prev_busy = 1'b0;

    always #5 clk = ~clk;

    command_queue #(.DEPTH(DEPTH), .GUARD_CYCLES(GUARD)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_execute  (in_execute),
        .in_command  (in_command),
        .in_busy     (in_busy),
        .out_execute (out_execute),
        .out_command (out_command),
        .out_busy    (out_busy),
        .flush       (flush),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    // TPU model: busy rises the cycle after an issue and stays up 20 cycles.
    always @(posedge clk) begin
        if (out_execute === 1'b1) tpu_cnt <= 20;
        else if (tpu_cnt != 0)    tpu_cnt <= tpu_cnt - 1;
    end
    assign tpu_busy = (tpu_cnt != 0);
    assign out_busy = tpu_en ? tpu_busy : busy_man;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] cmd, input logic accept);
        in_execute = 1'b1;
        in_command = cmd;
        if (accept) sb.push_back(cmd);
        tick();
        in_execute = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (sb.size() != 0 && k < max_cyc) begin
            tick();
            k++;
        end
        check("drain_within_budget", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset && out_execute === 1'b1) begin
            check("no_issue_while_busy", 64'(prev_busy), 64'd0);
            check("issue_spacing", 64'((cyc - last_exec) >= GUARD + 2), 64'd1);
            last_exec = cyc;
            check("issue_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                logic [47:0] exp_cmd;
                exp_cmd = sb.pop_front();
                check("out_command", 64'(out_command), 64'(exp_cmd));
            end
        end
        prev_busy = out_busy;
    end

    typedef struct {
        logic        push;
        logic [47:0] cmd;
        logic        accept;
        logic [2:0]  exp_level;
        logic        exp_in_busy;
        logic        exp_ovf;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 48'hC000_0000_0000, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 48'hC111_1111_1111, 1'b1, 3'd2, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 48'hC222_2222_2222, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 48'hC333_3333_3333, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0};
        vecs[4] = '{1'b1, 48'hC444_4444_4444, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1};
        vecs[5] = '{1'b0, 48'h0,              1'b0, 3'd4, 1'b1, 1'b1, 8'd1};

        reset      = 1'b1;
        in_execute = 1'b0;
        in_command = '0;
        flush      = 1'b0;
        busy_man   = 1'b0;
        tpu_en     = 1'b0;
        tick(2);
        check("rst_in_busy",     64'(in_busy),     64'd0);
        check("rst_out_execute", 64'(out_execute), 64'd0);
        check("rst_out_command", 64'(out_command), 64'd0);
        check("rst_level",       64'(level),       64'd0);
        check("rst_overflow",    64'(overflow),    64'd0);
        check("rst_drop_count",  64'(drop_count),  64'd0);
        reset = 1'b0;
        tick(5);

        // Latency: push in cycle N, issue visible in N+2 only.
        in_execute = 1'b1;
        in_command = 48'h0102_0304_0506;
        sb.push_back(48'h0102_0304_0506);
        tick();
        in_execute = 1'b0;
        check("lat_level_n1", 64'(level),       64'd1);
        check("lat_exec_n1",  64'(out_execute), 64'd0);
        tick();
        check("lat_exec_n2",  64'(out_execute), 64'd1);
        check("lat_cmd_n2",   64'(out_command), 64'h0102_0304_0506);
        tick();
        check("lat_exec_n3",  64'(out_execute), 64'd0);
        check("lat_level_n3", 64'(level),       64'd0);
        tick(6);

        // Fill and overflow while the TPU is busy.
        busy_man = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            in_execute = vecs[i].push;
            in_command = vecs[i].cmd;
            if (vecs[i].accept) sb.push_back(vecs[i].cmd);
            tick();
            in_execute = 1'b0;
            check($sformatf("vec%0d_level", i),    64'(level),      64'(vecs[i].exp_level));
            check($sformatf("vec%0d_in_busy", i),  64'(in_busy),    64'(vecs[i].exp_in_busy));
            check($sformatf("vec%0d_overflow", i), 64'(overflow),   64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_drop", i),     64'(drop_count), 64'(vecs[i].exp_drop));
        end
        busy_man = 1'b0;
        wait_drain(60);
        tick(6);

        // TPU model paces issues by its own busy.
        tpu_en = 1'b1;
        push(48'hE000_0000_00E0, 1'b1);
        push(48'hE111_1111_11E1, 1'b1);
        push(48'hE222_2222_22E2, 1'b1);
        wait_drain(200);
        tick(30);
        tpu_en = 1'b0;
        tick(4);

        // Full queue: push and issuing pop in the same cycle.
        busy_man = 1'b1;
        tick();
        push(48'hD000_0000_0000, 1'b1);
        push(48'hD111_1111_1111, 1'b1);
        push(48'hD222_2222_2222, 1'b1);
        push(48'hD333_3333_3333, 1'b1);
        check("full_level", 64'(level), 64'd4);
        in_execute = 1'b1;
        in_command = 48'hD444_4444_4444;
        busy_man   = 1'b0;
        tick();
        in_execute = 1'b0;
        check("pushpop_level",   64'(level),       64'd3);
        check("pushpop_drop",    64'(drop_count),  64'd2);
        check("pushpop_exec",    64'(out_execute), 64'd1);
        check("pushpop_in_busy", 64'(in_busy),     64'd0);
        wait_drain(60);
        tick(6);

        // Flush discards queued commands and a same-cycle push.
        busy_man = 1'b1;
        tick();
        push(48'hF000_0000_0000, 1'b0);
        push(48'hF111_1111_1111, 1'b0);
        push(48'hF222_2222_2222, 1'b0);
        check("preflush_level", 64'(level), 64'd3);
        flush      = 1'b1;
        in_execute = 1'b1;
        in_command = 48'hF333_3333_3333;
        tick();
        flush      = 1'b0;
        in_execute = 1'b0;
        check("flush_level",    64'(level),      64'd0);
        check("flush_in_busy",  64'(in_busy),    64'd0);
        check("flush_overflow", 64'(overflow),   64'd1);
        check("flush_drop",     64'(drop_count), 64'd2);
        busy_man = 1'b0;
        tick(12);
        push(48'h0D0D_0D0D_0D0D, 1'b1);
        wait_drain(20);
        check("postflush_overflow", 64'(overflow), 64'd1);
        tick(6);

        // Saturating drop counter, then reset mid-stream.
        busy_man = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            in_execute = 1'b1;
            in_command = 48'hAA00_0000_0000 | 48'(i);
            tick();
        end
        check("sat_drop",     64'(drop_count), 64'd255);
        check("sat_overflow", 64'(overflow),   64'd1);
        check("sat_level",    64'(level),      64'd4);
        check("sat_in_busy",  64'(in_busy),    64'd1);
        reset = 1'b1;
        tick();
        check("midrst_in_busy",     64'(in_busy),     64'd0);
        check("midrst_out_execute", 64'(out_execute), 64'd0);
        check("midrst_out_command", 64'(out_command), 64'd0);
        check("midrst_level",       64'(level),       64'd0);
        check("midrst_overflow",    64'(overflow),    64'd0);
        check("midrst_drop_count",  64'(drop_count),  64'd0);
        reset      = 1'b0;
        in_execute = 1'b0;
        tick();
        busy_man = 1'b0;
        tick(10);
        check("final_level", 64'(level), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
